plab5_mcore_sec_mem_responder: RTL
==================================

// Module: plab5_mcore_sec_mem_responder
// PURPOSE
//  Memory-side responder for the access-controlled mem port: accepts one vc-mem request, performs a word-array read/write, returns one response.
//  Enforces the secure partition at the target: domain-0 accesses at or above sec_par_addr are blocked.
//  Tags each response with the request's domain. Single outstanding transaction; sits behind the memory access controller.
// PARAMETERS
//  p_mem_nbytes    1<<16  memory size in bytes (power of 2; words = p_mem_nbytes/4)
//  p_opaque_nbits  8      opaque field width (o)
//  p_addr_nbits    32     address width (a)
//  p_data_nbits    32     data width (d); fixed at 32
//  p_viol_nbits    8      violation counter width
// PORTS
//  clk              in   1      clock
//  reset            in   1      synchronous, active-high reset
//  req_domain       in   1      domain of the presented request; 1 = secure
//  sec_par_addr     in   a      partition base; addresses >= this value are secure
//  mem_req_control  in   3+o+a+2  {type[3], opaque[o], addr[a], len[2]}
//  mem_req_data     in   d      write data
//  mem_req_val      in   1      request valid
//  mem_req_rdy      out  1      request ready
//  mem_resp_control out  3+o+2  {type[3], opaque[o], len[2]}
//  mem_resp_data    out  d      read data (0 for writes and blocked reads)
//  mem_resp_val     out  1      response valid
//  mem_resp_rdy     in   1      response ready
//  resp_domain      out  1      domain of the transaction in flight/responding
//  viol             out  1      response is for a blocked access (valid with resp_val)
//  viol_count       out  p_viol_nbits  saturating count of blocked accesses
// BEHAVIOUR
//  Reset: state IDLE; mem_req_rdy=1, mem_resp_val=0, viol=0, viol_count=0, resp_domain=0; memory contents are not cleared.
//  Type encodings: READ=0, WRITE=1, INIT=2 (INIT is WRITE with no violation check). Any other type: respond with data 0, no state change.
//  FSM IDLE -> ACCESS -> [WAIT] -> RESP -> IDLE.
//   IDLE: rdy=1. On val&&rdy, latch control, data, req_domain -> ACCESS.
//   ACCESS: rdy=0. Compute blocked = (type!=INIT) && !domain && addr>=sec_par_addr.
//     Blocked: no write; read data 0; viol_count += 1, saturating at all-ones.
//     Otherwise READ/WRITE the word at addr[log2(p_mem_nbytes)-1:2]. Higher address bits are ignored (wrap-around).
//   RESP: val=1. resp_control={type, opaque, len}. Hold all response outputs stable until rdy; on val&&rdy -> IDLE.
//  Latency: request accepted at cycle N produces resp_val at N+2 (no WAIT). rdy returns high at cycle M+1 after the response handshake at M.
//  len: 0 = full 4 bytes; 1..3 = that many bytes starting at byte offset addr[1:0].
//    Write: byte-masked; bytes past offset 3 are dropped.
//    Read: selected bytes right-justified and zero-extended.
//  resp_domain: updated only at request acceptance; held through RESP.
//  Simultaneous events: a request with val=1 during RESP is not accepted (rdy=0).
//  Reset mid-transaction: the transaction is dropped, no response is issued, and any write not yet done in ACCESS is not performed.
// CONFIGURATION
//  PLAB5_MEM_RESP_DELAY_EN defined:
//    - Adds parameter p_delay (default 3) and WAIT state.
//    - ACCESS loads a down-counter with p_delay; WAIT decrements it and moves to RESP when it reaches 0.
//    - Latency becomes N+2+p_delay. p_delay=0 skips WAIT.
//  Undefined: no WAIT state, no counter; ACCESS -> RESP directly.
// STRUCTURE
//  Shared package/header (vc-mem-msgs): type encodings, field offsets, REQ/RESP control widths, STATE_* localparams.
//  One sub-module, plab5_mcore_sec_mem_array: word array with sync write, byte-enable write, and comb read.
//  The FSM, partition check and counter stay in the top module.
// TESTING
//  1. Domain 1, WRITE addr 0x100 data 0xdeadbeef, then READ 0x100 -> resp type=1 data=0; then resp type=0 data=0xdeadbeef, viol=0.
//  2. sec_par_addr=0xc000, domain 0: WRITE 0xc004 = 0x1234, then domain 1 READ 0xc004 -> blocked write: viol=1 and viol_count=1; the read returns the prior value.
//  3. Domain 0 READ 0xc000 with resp_rdy low for 5 cycles -> val and data held stable; resp_domain=0; req_rdy=0 throughout.
//  4. WRITE 0x200 len=1 offset 2 data 0xab over 0x11223344 -> word becomes 0x11ab3344; READ len=2 at 0x202 returns 0x000011ab.
//  5. 256 blocked domain-0 accesses -> viol_count saturates at 0xff.
//  6. Reset asserted during ACCESS of a WRITE to 0x300 -> no response; rdy=1 the cycle after reset; 0x300 unchanged.

Source files
------------

// File: rtl/plab5_mcore_sec_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// plab5_mcore_sec_mem_responder_pkg
//   Shared vc-mem message definitions for the secure memory responder:
//   request type encodings, control-field widths, FSM state constants and
//   the byte-lane helpers used to build masked writes and right-justified
//   sub-word reads.
//   Request control layout : {type[3], opaque[o], addr[a], len[2]}
//   Response control layout: {type[3], opaque[o], len[2]}
// -----------------------------------------------------------------------------
package plab5_mcore_sec_mem_responder_pkg;

    localparam int MEM_TYPE_NBITS = 3;
    localparam int MEM_LEN_NBITS  = 2;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
    localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ACCESS = 2'd1;
    localparam logic [1:0] STATE_WAIT   = 2'd2;
    localparam logic [1:0] STATE_RESP   = 2'd3;

    function automatic int mem_req_ctrl_nbits(input int o, input int a);
        return MEM_TYPE_NBITS + o + a + MEM_LEN_NBITS;
    endfunction

    function automatic int mem_resp_ctrl_nbits(input int o);
        return MEM_TYPE_NBITS + o + MEM_LEN_NBITS;
    endfunction

    // Byte lanes touched by a write; lanes past offset 3 fall off the top.
    function automatic logic [3:0] byte_mask(input logic [1:0] len, input logic [1:0] off);
        logic [7:0] m;
        if (len == 2'd0) return 4'hf;
        m = ((8'd1 << len) - 8'd1) << off;
        return m[3:0];
    endfunction

    // Move the low bytes of the write data up to the addressed byte offset.
    function automatic logic [31:0] write_align(input logic [31:0] data, input logic [1:0] len,
                                                input logic [1:0] off);
        if (len == 2'd0) return data;
        return data << {off, 3'b000};
    endfunction

    // Right-justify and zero-extend the selected bytes of a stored word.
    function automatic logic [31:0] read_align(input logic [31:0] word, input logic [1:0] len,
                                               input logic [1:0] off);
        logic [31:0] keep;
        if (len == 2'd0) return word;
        keep = (32'd1 << {len, 3'b000}) - 32'd1;
        return (word >> {off, 3'b000}) & keep;
    endfunction

endpackage

// File: rtl/plab5_mcore_sec_mem_responder_array.sv
// -----------------------------------------------------------------------------
// plab5_mcore_sec_mem_array
//   Word-organised storage: combinational read, synchronous byte-enabled
//   write. Contents are never cleared.
//   Ports:
//     clk    in   clock
//     wen    in   write enable
//     wbe    in   [4]  byte enables for the write
//     idx    in   [p_idx_nbits] word index (shared by read and write)
//     wdata  in   [32] write data, already aligned to the byte lanes
//     rdata  out  [32] word currently stored at idx
// -----------------------------------------------------------------------------
module plab5_mcore_sec_mem_array #(
    parameter int p_idx_nbits = 14
)(
    input  logic                   clk,
    input  logic                   wen,
    input  logic [3:0]             wbe,
    input  logic [p_idx_nbits-1:0] idx,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata
);

    localparam int c_nwords = 1 << p_idx_nbits;

    logic [31:0] mem [c_nwords];

    assign rdata = mem[idx];

    always_ff @(posedge clk) begin
        if (wen) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/plab5_mcore_sec_mem_responder.sv
// -----------------------------------------------------------------------------
// plab5_mcore_sec_mem_responder
//   Memory-side responder behind the access controller. Accepts one vc-mem
//   request at a time, reads or writes the word array, and returns one
//   response tagged with the request's domain. Domain-0 READ/WRITE accesses
//   at or above sec_par_addr are blocked: no write, read data 0, viol set
//   and the saturating viol_count bumped. INIT writes skip the check; any
//   other type answers with data 0 and changes nothing.
//   Optional build macro PLAB5_MEM_RESP_DELAY_EN adds parameter p_delay and
//   a WAIT state that stretches the response latency by p_delay cycles.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     req_domain        domain of the presented request (1 = secure)
//     sec_par_addr      secure partition base address
//     mem_req_*         request channel {type, opaque, addr, len} + data
//     mem_resp_*        response channel {type, opaque, len} + data
//     resp_domain       domain of the transaction in flight / responding
//     viol              response belongs to a blocked access
//     viol_count        saturating count of blocked accesses
// -----------------------------------------------------------------------------
module plab5_mcore_sec_mem_responder
    import plab5_mcore_sec_mem_responder_pkg::*;
#(
    parameter int p_mem_nbytes   = 1 << 16,
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_viol_nbits   = 8
`ifdef PLAB5_MEM_RESP_DELAY_EN
    , parameter int p_delay      = 3
`endif
)(
    input  logic                                                    clk,
    input  logic                                                    reset,
    input  logic                                                    req_domain,
    input  logic [p_addr_nbits-1:0]                                 sec_par_addr,
    input  logic [mem_req_ctrl_nbits(p_opaque_nbits, p_addr_nbits)-1:0] mem_req_control,
    input  logic [p_data_nbits-1:0]                                 mem_req_data,
    input  logic                                                    mem_req_val,
    output logic                                                    mem_req_rdy,
    output logic [mem_resp_ctrl_nbits(p_opaque_nbits)-1:0]          mem_resp_control,
    output logic [p_data_nbits-1:0]                                 mem_resp_data,
    output logic                                                    mem_resp_val,
    input  logic                                                    mem_resp_rdy,
    output logic                                                    resp_domain,
    output logic                                                    viol,
    output logic [p_viol_nbits-1:0]                                 viol_count
);

    localparam int c_idx_nbits = $clog2(p_mem_nbytes) - 2;

    function automatic logic [p_viol_nbits-1:0] sat_inc(input logic [p_viol_nbits-1:0] v);
        return (&v) ? v : v + p_viol_nbits'(1);
    endfunction

    logic [1:0]                state;
    logic [2:0]                new_type,   txn_type;
    logic [p_opaque_nbits-1:0] new_opaque, txn_opaque;
    logic [p_addr_nbits-1:0]   new_addr,   txn_addr;
    logic [1:0]                new_len,    txn_len;
    logic [31:0]               txn_data;
    logic [31:0]               resp_data;
    logic [31:0]               rd_word;
    logic                      viol_q;
    logic                      is_read, is_write, checked, blocked, wen;

`ifdef PLAB5_MEM_RESP_DELAY_EN
    localparam int c_dly_nbits = $clog2(p_delay + 2);
    logic [c_dly_nbits-1:0] dly_cnt;
`endif

    assign {new_type, new_opaque, new_addr, new_len} = mem_req_control;

    assign is_read  = (txn_type == MEM_TYPE_READ);
    assign is_write = (txn_type == MEM_TYPE_WRITE) || (txn_type == MEM_TYPE_INIT);
    assign checked  = (txn_type == MEM_TYPE_READ) || (txn_type == MEM_TYPE_WRITE);
    assign blocked  = checked && !resp_domain && (txn_addr >= sec_par_addr);
    // Reset in the ACCESS cycle must also cancel the write.
    assign wen      = (state == STATE_ACCESS) && is_write && !blocked && !reset;

    plab5_mcore_sec_mem_array #(
        .p_idx_nbits (c_idx_nbits)
    ) array (
        .clk   (clk),
        .wen   (wen),
        .wbe   (byte_mask(txn_len, txn_addr[1:0])),
        .idx   (txn_addr[c_idx_nbits+1:2]),
        .wdata (write_align(txn_data, txn_len, txn_addr[1:0])),
        .rdata (rd_word)
    );

    // Control: FSM, domain tag, violation flag and counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= STATE_IDLE;
            resp_domain <= 1'b0;
            viol_q      <= 1'b0;
            viol_count  <= '0;
`ifdef PLAB5_MEM_RESP_DELAY_EN
            dly_cnt     <= '0;
`endif
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (mem_req_val) begin
                        state       <= STATE_ACCESS;
                        resp_domain <= req_domain;
                    end
                end
                STATE_ACCESS: begin
                    viol_q <= blocked;
                    if (blocked) viol_count <= sat_inc(viol_count);
`ifdef PLAB5_MEM_RESP_DELAY_EN
                    dly_cnt <= c_dly_nbits'(p_delay);
                    state   <= (p_delay == 0) ? STATE_RESP : STATE_WAIT;
`else
                    state <= STATE_RESP;
`endif
                end
`ifdef PLAB5_MEM_RESP_DELAY_EN
                STATE_WAIT: begin
                    dly_cnt <= dly_cnt - 1'b1;
                    if (dly_cnt <= c_dly_nbits'(1)) state <= STATE_RESP;
                end
`endif
                STATE_RESP: begin
                    if (mem_resp_rdy) begin
                        state  <= STATE_IDLE;
                        viol_q <= 1'b0;
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

    // Data: request capture and response data, no reset needed
    always_ff @(posedge clk) begin
        if (state == STATE_IDLE && mem_req_val) begin
            txn_type   <= new_type;
            txn_opaque <= new_opaque;
            txn_addr   <= new_addr;
            txn_len    <= new_len;
            txn_data   <= mem_req_data;
        end
        if (state == STATE_ACCESS) begin
            resp_data <= (is_read && !blocked) ? read_align(rd_word, txn_len, txn_addr[1:0]) : 32'd0;
        end
    end

    assign mem_req_rdy      = (state == STATE_IDLE);
    assign mem_resp_val     = (state == STATE_RESP);
    assign mem_resp_control = {txn_type, txn_opaque, txn_len};
    assign mem_resp_data    = resp_data;
    assign viol             = viol_q && mem_resp_val;

endmodule
